// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a req/ack handshake and a fixed response latency.
// Optional byte-enable stores are compiled in when DMEM_BYTE_MASK_EN is defined.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4,
    localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_MASK_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               mis_q, mis_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q;
    logic [3:0]         be_eff;
    logic               load_rd;
    logic [ADDR_W-1:0]  rd_idx;
    logic               wr_en;

    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits alias onto the storage and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_W+2];

`ifdef DMEM_BYTE_MASK_EN
    logic [3:0] be_q, be_d;
    assign be_eff = be_q;
`else
    assign be_eff = 4'hF;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef DMEM_BYTE_MASK_EN
        be_d    = be_q;
`endif
        load_rd = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    mis_d   = |addr_i[1:0];
                    idx_d   = addr_i[ADDR_W+1:2];
                    wdata_d = wdata_i;
`ifdef DMEM_BYTE_MASK_EN
                    be_d    = be_i;
`endif
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        // Entering RESP straight from IDLE: read with the live address.
                        state_d = RESP;
                        load_rd = ~we_i & ~(|addr_i[1:0]);
                        rd_idx  = addr_i[ADDR_W+1:2];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    load_rd = ~we_q & ~mis_q;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
`ifdef DMEM_BYTE_MASK_EN
            be_q    <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
`ifdef DMEM_BYTE_MASK_EN
            be_q    <= be_d;
`endif
        end
    end

    // Registered read port; the value is held until the next aligned load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
        end else if (load_rd) begin
            rdata_q <= mem[rd_idx];
        end
    end

    // Reset in the RESP cycle abandons the store.
    assign wr_en = (state_q == RESP) & we_q & ~mis_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be_eff[b]) begin
                mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    assign ack_o   = (state_q == RESP);
    assign err_o   = (state_q == RESP) & mis_q;
    assign rdata_o = rdata_q;
    assign stall_o = req_i & ~ack_o;

endmodule
